ps2_keyboard_rx: RTL and testbench

PS/2 keyboard receiver and scan-code decoder. It deserialises device-to-host frames from the keyboard connector into bytes, then strips the E0/F0 prefixes into make/break key events. It sits directly upstream of the game's keyboard input handler, which consumes `held_code`/`key_valid` to steer player directions and detect the space-bar start.

---
 rtl/ps2_keyboard_rx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
// PS/2 keyboard receiver and scan-code decoder. Deserialises device-to-host
// frames (start, 8 data LSB-first, odd parity, stop) into bytes, then folds
// the E0/F0 prefixes into make/break key events and tracks the held key.
//
// Handshake: there is no ready. code_valid, key_valid and frame_err are
// single-cycle pulses; the associated data outputs hold until their next
// update, so a consumer samples data only in a cycle where its valid is high.
//
// Ports
//   DIV_CLK        system clock, rising edge
//   reset          synchronous, active-high
//   ps2_clk        raw PS/2 clock pin (asynchronous)
//   ps2_data       raw PS/2 data pin (asynchronous)
//   scan_code      last correctly received raw byte
//   code_valid     pulse when scan_code updates
//   key_code       key byte of the last key event, prefixes removed
//   key_extended   last event was preceded by E0
//   key_release    last event was preceded by F0
//   key_valid      pulse when key_code/key_extended/key_release update
//   held_code      most recently pressed key still down, 0x00 when none
//   held_ext       extended flag belonging to held_code
//   frame_err      pulse on start/parity/stop error or watchdog timeout
//   dbg_rx_state   receiver FSM state (0 idle, 1 shift, 2 stop)
//   dbg_dec_state  decoder FSM state (0 base, 1 ext, 2 brk, 3 ext_brk)
module ps2_keyboard_rx #(
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       DIV_CLK,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scan_code,
   output logic       code_valid,
   output logic [7:0] key_code,
   output logic       key_extended,
   output logic       key_release,
   output logic       key_valid,
   output logic [7:0] held_code,
   output logic       held_ext,
   output logic       frame_err,
   output logic [1:0] dbg_rx_state,
   output logic [1:0] dbg_dec_state
);

   typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_SHIFT = 2'd1, RX_STOP = 2'd2} rx_state_t;
   typedef enum logic [1:0] {D_BASE = 2'd0, D_EXT = 2'd1, D_BRK = 2'd2, D_EXT_BRK = 2'd3} dec_state_t;

   localparam logic [17:0] WD_LAST = 18'(TIMEOUT_CYCLES - 1);

   rx_state_t  rx_state;
   dec_state_t dec_state;
   logic       clk_s1, clk_s2, clk_s3;
   logic       dat_s1, dat_s2;
   logic       fe;
   logic [3:0] bit_cnt;
   logic [7:0] shift_reg;
   logic       parity_bit;
   logic [17:0] wd_cnt;
   logic       wd_expired;
   logic       cur_ext, cur_brk, non_key;

   assign dbg_rx_state  = rx_state;
   assign dbg_dec_state = dec_state;

   // Synchronisers reset to 1 (bus idle level) so leaving reset never
   // fabricates a falling edge. Data sees the same two stages as the clock.
   always_ff @(posedge DIV_CLK) begin
      if (reset) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_s3 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   assign fe = clk_s3 & ~clk_s2;

   // fe takes priority over expiry: the counter clears instead.
   assign wd_expired = (rx_state != RX_IDLE) && !fe && (wd_cnt == WD_LAST);

   always_ff @(posedge DIV_CLK) begin
      if (reset) begin
         rx_state   <= RX_IDLE;
         bit_cnt    <= 4'd0;
         shift_reg  <= 8'h00;
         parity_bit <= 1'b0;
         wd_cnt     <= 18'd0;
         scan_code  <= 8'h00;
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (rx_state == RX_IDLE || fe || wd_expired) wd_cnt <= 18'd0;
         else                                         wd_cnt <= wd_cnt + 18'd1;

         if (wd_expired) begin
            rx_state  <= RX_IDLE;
            frame_err <= 1'b1;
         end else begin
            case (rx_state)
               RX_IDLE: begin
                  if (fe) begin
                     if (!dat_s2) begin
                        rx_state <= RX_SHIFT;
                        bit_cnt  <= 4'd0;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end
               end
               RX_SHIFT: begin
                  if (fe) begin
                     if (bit_cnt == 4'd8) begin
                        parity_bit <= dat_s2;
                        rx_state   <= RX_STOP;
                     end else begin
                        shift_reg <= {dat_s2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                     end
                  end
               end
               RX_STOP: begin
                  if (fe) begin
                     rx_state <= RX_IDLE;
                     // Odd parity: data bits plus parity must XOR to 1.
                     if (dat_s2 && (^{shift_reg, parity_bit})) begin
                        scan_code  <= shift_reg;
                        code_valid <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end
               end
               default: rx_state <= RX_IDLE;
            endcase
         end
      end
   end

   assign cur_ext = (dec_state == D_EXT) || (dec_state == D_EXT_BRK);
   assign cur_brk = (dec_state == D_BRK) || (dec_state == D_EXT_BRK);
   assign non_key = (scan_code == 8'h00) || (scan_code == 8'hAA) || (scan_code == 8'hEE) ||
                    (scan_code == 8'hFA) || (scan_code == 8'hFE) || (scan_code == 8'hFF);

   always_ff @(posedge DIV_CLK) begin
      if (reset) begin
         dec_state    <= D_BASE;
         key_code     <= 8'h00;
         key_extended <= 1'b0;
         key_release  <= 1'b0;
         key_valid    <= 1'b0;
         held_code    <= 8'h00;
         held_ext     <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (frame_err) begin
            dec_state <= D_BASE;
         end else if (code_valid) begin
            // E0 only acts as a prefix before any F0 has been seen.
            if (scan_code == 8'hE0 && !cur_brk) begin
               dec_state <= D_EXT;
            end else if (scan_code == 8'hF0) begin
               dec_state <= cur_ext ? D_EXT_BRK : D_BRK;
            end else if (non_key) begin
               dec_state <= D_BASE;
            end else begin
               key_code     <= scan_code;
               key_extended <= cur_ext;
               key_release  <= cur_brk;
               key_valid    <= 1'b1;
               dec_state    <= D_BASE;
               if (!cur_brk) begin
                  held_code <= scan_code;
                  held_ext  <= cur_ext;
               end else if (scan_code == held_code && cur_ext == held_ext) begin
                  held_code <= 8'h00;
                  held_ext  <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
module tb_ps2_keyboard_rx;
   localparam int TO = 100;  // watchdog length used for this bench
   localparam int H  = 8;    // half PS/2 bit period in DIV_CLK cycles

   logic       DIV_CLK = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] scan_code, key_code, held_code;
   logic       code_valid, key_extended, key_release, key_valid, held_ext, frame_err;
   logic [1:0] dbg_rx_state, dbg_dec_state;

   // clock / reset
   always #5 DIV_CLK = ~DIV_CLK;

   ps2_keyboard_rx #(.TIMEOUT_CYCLES(TO)) dut (
      .DIV_CLK(DIV_CLK), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .scan_code(scan_code), .code_valid(code_valid), .key_code(key_code),
      .key_extended(key_extended), .key_release(key_release), .key_valid(key_valid),
      .held_code(held_code), .held_ext(held_ext), .frame_err(frame_err),
      .dbg_rx_state(dbg_rx_state), .dbg_dec_state(dbg_dec_state)
   );

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       rel;
      logic [7:0] held;
      logic       held_ext;
   } ev_t;

   // scoreboard
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   ev_t        exp_ev_q[$];
   ev_t        obs_ev_q[$];
   int         exp_ferr = 0, obs_ferr = 0, lat_bad = 0, width_bad = 0;
   logic       prev_cv = 1'b0, prev_kv = 1'b0, prev_fe = 1'b0;
   int         compared = 0, mismatched = 0;

   // reference model: pending-prefix flags plus held key
   bit         m_ext = 0, m_brk = 0;
   logic [7:0] m_held = 8'h00;
   bit         m_held_ext = 0;

   // monitor, sampled away from the active edge
   always @(negedge DIV_CLK) begin
      if (code_valid) obs_q.push_back(scan_code);
      if (key_valid) begin
         obs_ev_q.push_back({key_code, key_extended, key_release, held_code, held_ext});
         if (!prev_cv) lat_bad++;
      end
      if (frame_err) obs_ferr++;
      if ((code_valid && prev_cv) || (key_valid && prev_kv) || (frame_err && prev_fe)) width_bad++;
      prev_cv = code_valid;
      prev_kv = key_valid;
      prev_fe = frame_err;
   end

   function automatic bit is_nonkey(input logic [7:0] b);
      return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
             (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
   endfunction

   task automatic model_byte(input logic [7:0] b);
      exp_q.push_back(b);
      if (b == 8'hE0 && !m_brk) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (is_nonkey(b)) begin m_ext = 0; m_brk = 0; end
      else begin
         if (!m_brk) begin
            m_held = b; m_held_ext = m_ext;
         end else if (m_held == b && m_held_ext == m_ext) begin
            m_held = 8'h00; m_held_ext = 0;
         end
         exp_ev_q.push_back({b, m_ext, m_brk, m_held, m_held_ext});
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic model_reset();
      m_ext = 0; m_brk = 0; m_held = 8'h00; m_held_ext = 0;
   endtask

   task automatic clear_sb();
      exp_q.delete(); obs_q.delete(); exp_ev_q.delete(); obs_ev_q.delete();
      exp_ferr = 0; obs_ferr = 0;
   endtask

   // driver: start, 8 data LSB-first, odd parity, stop; nbits < 11 truncates
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         repeat (H) @(negedge DIV_CLK);
         ps2_clk = 1'b0;
         repeat (H) @(negedge DIV_CLK);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (H) @(negedge DIV_CLK);
   endtask

   task automatic send_key(input logic [7:0] b, input bit bad_par);
      send_frame(b, bad_par, 11);
      if (bad_par) begin exp_ferr++; m_ext = 0; m_brk = 0; end
      else model_byte(b);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (4) @(negedge DIV_CLK);
      compared++;
      if ({scan_code, key_code, held_code} !== 24'h0) begin
         mismatched++; $display("FAIL reset_codes: got %h want 000000", {scan_code, key_code, held_code});
      end
      compared++;
      if ({code_valid, key_extended, key_release, key_valid, held_ext, frame_err} !== 6'b0) begin
         mismatched++; $display("FAIL reset_flags: got %b want 000000",
                                {code_valid, key_extended, key_release, key_valid, held_ext, frame_err});
      end
      compared++;
      if ({dbg_rx_state, dbg_dec_state} !== 4'b0) begin
         mismatched++; $display("FAIL reset_states: got %b want 0000", {dbg_rx_state, dbg_dec_state});
      end
      reset = 1'b0;
      repeat (4) @(negedge DIV_CLK);
      model_reset();
   endtask

   task automatic test_make();
      clear_sb();
      send_key(8'h1D, 0);
      compared++;
      if (obs_q.size() != 1 || obs_q[0] !== 8'h1D) begin
         mismatched++; $display("FAIL make_code: got n=%0d %h want 1d", obs_q.size(), obs_q.size() ? obs_q[0] : 8'h0);
      end
      compared++;
      if (obs_ev_q.size() != 1 || obs_ev_q[0] !== ev_t'({8'h1D, 1'b0, 1'b0, 8'h1D, 1'b0})) begin
         mismatched++; $display("FAIL make_event: got n=%0d %h want %h", obs_ev_q.size(),
                                obs_ev_q.size() ? obs_ev_q[0] : ev_t'(0), ev_t'({8'h1D, 1'b0, 1'b0, 8'h1D, 1'b0}));
      end
      compared++;
      if (lat_bad != 0) begin
         mismatched++; $display("FAIL make_latency: got %0d late events want 0", lat_bad);
      end
   endtask

   task automatic test_ext_break();
      logic [7:0] seq[5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
      clear_sb();
      foreach (seq[i]) send_key(seq[i], 0);
      compared++;
      if (obs_ev_q.size() != 2) begin
         mismatched++; $display("FAIL extbrk_count: got %0d events want 2", obs_ev_q.size());
      end
      foreach (exp_ev_q[i]) if (i < obs_ev_q.size()) begin
         compared++;
         if (obs_ev_q[i] !== exp_ev_q[i]) begin
            mismatched++; $display("FAIL extbrk_event%0d: got %h want %h", i, obs_ev_q[i], exp_ev_q[i]);
         end
      end
   endtask

   task automatic test_overlap();
      logic [7:0] seq[6] = '{8'h1D, 8'h29, 8'hF0, 8'h1D, 8'hF0, 8'h29};
      clear_sb();
      foreach (seq[i]) send_key(seq[i], 0);
      compared++;
      if (obs_ev_q.size() != exp_ev_q.size()) begin
         mismatched++; $display("FAIL overlap_count: got %0d want %0d", obs_ev_q.size(), exp_ev_q.size());
      end
      foreach (exp_ev_q[i]) if (i < obs_ev_q.size()) begin
         compared++;
         if (obs_ev_q[i] !== exp_ev_q[i]) begin
            mismatched++; $display("FAIL overlap_event%0d: got %h want %h", i, obs_ev_q[i], exp_ev_q[i]);
         end
      end
   endtask

   task automatic test_parity_err();
      clear_sb();
      send_key(8'h1C, 1);
      compared++;
      if (obs_ferr != 1 || obs_q.size() != 0) begin
         mismatched++; $display("FAIL parity_err: got ferr=%0d codes=%0d want ferr=1 codes=0", obs_ferr, obs_q.size());
      end
      send_key(8'h1C, 0);
      compared++;
      if (obs_q.size() != 1 || obs_q[0] !== 8'h1C) begin
         mismatched++; $display("FAIL parity_recover: got n=%0d want one 1c", obs_q.size());
      end
   endtask

   task automatic test_timeout();
      clear_sb();
      send_frame(8'h55, 0, 5);
      repeat (TO + 50) @(negedge DIV_CLK);
      exp_ferr++; m_ext = 0; m_brk = 0;
      compared++;
      if (obs_ferr != exp_ferr || obs_q.size() != 0) begin
         mismatched++; $display("FAIL timeout_err: got ferr=%0d codes=%0d want ferr=%0d codes=0", obs_ferr, obs_q.size(), exp_ferr);
      end
      compared++;
      if (dbg_rx_state !== 2'd0) begin
         mismatched++; $display("FAIL timeout_idle: got state %0d want 0", dbg_rx_state);
      end
      send_key(8'h23, 0);
      compared++;
      if (obs_ev_q.size() != 1 || obs_ev_q[0] !== exp_ev_q[0]) begin
         mismatched++; $display("FAIL timeout_recover: got n=%0d want event %h", obs_ev_q.size(), exp_ev_q[0]);
      end
   endtask

   task automatic test_reset_mid();
      clear_sb();
      send_key(8'h1D, 0);
      send_key(8'hE0, 0);
      send_key(8'hF0, 0);
      send_frame(8'h6B, 0, 4);
      @(negedge DIV_CLK);
      reset = 1'b1;
      repeat (3) @(negedge DIV_CLK);
      compared++;
      if ({scan_code, key_code, held_code} !== 24'h0 ||
          {code_valid, key_extended, key_release, key_valid, held_ext, frame_err} !== 6'b0) begin
         mismatched++; $display("FAIL resetmid_outputs: got %h %b want all zero", {scan_code, key_code, held_code},
                                {code_valid, key_extended, key_release, key_valid, held_ext, frame_err});
      end
      reset = 1'b0;
      repeat (4) @(negedge DIV_CLK);
      model_reset();
      clear_sb();
      send_key(8'h6B, 0);
      compared++;
      if (obs_ev_q.size() != 1 || obs_ev_q[0] !== ev_t'({8'h6B, 1'b0, 1'b0, 8'h6B, 1'b0})) begin
         mismatched++; $display("FAIL resetmid_make: got n=%0d %h want %h", obs_ev_q.size(),
                                obs_ev_q.size() ? obs_ev_q[0] : ev_t'(0), ev_t'({8'h6B, 1'b0, 1'b0, 8'h6B, 1'b0}));
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pool[7] = '{8'h1D, 8'h29, 8'h75, 8'h6B, 8'h1C, 8'h23, 8'h12};
      logic [7:0] k;
      int r;
      clear_sb();
      repeat (30) begin
         k = pool[$urandom_range(0, 6)];
         r = $urandom_range(0, 9);
         if (r == 0) send_key(8'hAA, 0);
         if ($urandom_range(0, 1) == 1) send_key(8'hE0, 0);
         if ($urandom_range(0, 2) == 0) send_key(8'hF0, 0);
         if (r == 1) send_key(k, 1);
         send_key(k, 0);
      end
      compared++;
      if (obs_q.size() != exp_q.size() || obs_ferr != exp_ferr) begin
         mismatched++; $display("FAIL random_counts: got codes=%0d ferr=%0d want codes=%0d ferr=%0d",
                                obs_q.size(), obs_ferr, exp_q.size(), exp_ferr);
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         compared++;
         if (obs_q[i] !== exp_q[i]) begin
            mismatched++; $display("FAIL random_code%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      compared++;
      if (obs_ev_q.size() != exp_ev_q.size()) begin
         mismatched++; $display("FAIL random_events: got %0d want %0d", obs_ev_q.size(), exp_ev_q.size());
      end
      foreach (exp_ev_q[i]) if (i < obs_ev_q.size()) begin
         compared++;
         if (obs_ev_q[i] !== exp_ev_q[i]) begin
            mismatched++; $display("FAIL random_event%0d: got %h want %h", i, obs_ev_q[i], exp_ev_q[i]);
         end
      end
   endtask

   task automatic test_pulse_shape();
      compared++;
      if (width_bad != 0) begin
         mismatched++; $display("FAIL pulse_width: got %0d wide pulses want 0", width_bad);
      end
      compared++;
      if (lat_bad != 0) begin
         mismatched++; $display("FAIL key_latency: got %0d late events want 0", lat_bad);
      end
   endtask

   initial begin
      test_reset();
      test_make();
      test_ext_break();
      test_overlap();
      test_parity_err();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_pulse_shape();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // hard time limit so the run always ends
   initial begin
      #5_000_000;
      $display("FAIL time_limit: got no finish want finish");
      $fatal(1, "time limit");
   end
endmodule
